// File: rtl/poly_bank_loader.sv
// poly_bank_loader
//   Streams NTT coefficients into bank set A or B (load), or streams a bank
//   set back out in index order (dump). Index i maps to bank i mod NUM_BANKS,
//   address i / NUM_BANKS.
//
//   Optional build macro: LOADER_BITREV_EN -- bit-reverse the IDX_W-bit index
//   before the bank/address mapping (both load and dump).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start/mode/length operation request, sampled in IDLE only
//                     mode: 00 load A, 01 load B, 10 dump A, 11 dump B
//   s_valid/s_ready/s_data   input coefficient stream (load)
//   bank_we/bank_re   one-hot bank write/read enables
//   bank_set          0 = set A, 1 = set B
//   bank_addr         shared bank address
//   bank_wdata        write data
//   bank_rdata        read data, valid one cycle after bank_re
//   m_valid/m_ready/m_data   output coefficient stream (dump)
//   busy              not idle
//   done              one-cycle completion pulse
//   err               one-cycle pulse with done for an illegal length
module poly_bank_loader #(
  parameter int DATA_W     = 256,
  parameter int NUM_BANKS  = 8,
  parameter int BANK_DEPTH = 128,
  parameter int IDX_W      = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [IDX_W:0]                length,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS-1:0]          bank_re,
  output logic                          bank_set,
  output logic [$clog2(BANK_DEPTH)-1:0] bank_addr,
  output logic [DATA_W-1:0]             bank_wdata,
  input  logic [DATA_W-1:0]             bank_rdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = $clog2(BANK_DEPTH);
  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(NUM_BANKS * BANK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP,
    S_FLUSH,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;       // next index to write / read
  logic [IDX_W-1:0]  out_cnt;   // dump beats delivered so far
  logic [IDX_W-1:0]  last_idx;  // length - 1
  logic              set_r;
  logic              err_r;

  // Dump output buffer: 2-entry FIFO plus one read in flight.
  logic [DATA_W-1:0] buf_q [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic              rd_pend;

  logic              len_bad, beat, issue, pop, push, pop_buf;
  logic [1:0]        fill;
  logic [IDX_W-1:0]  pidx;
  logic [BANK_W-1:0] bsel;
  logic [ADDR_W-1:0] paddr;
  logic [NUM_BANKS-1:0] bank_oh;

  always_comb begin
    pidx = '0;
`ifdef LOADER_BITREV_EN
    for (int unsigned i = 0; i < IDX_W; i++) pidx[i] = idx[IDX_W-1-i];
`else
    pidx = idx;
`endif
  end

  assign bsel    = pidx[BANK_W-1:0];
  assign paddr   = pidx[BANK_W +: ADDR_W];
  assign bank_oh = NUM_BANKS'(1) << bsel;

  assign len_bad = (length == '0) || (length > MAX_LEN);
  assign beat    = (state == S_LOAD) && s_valid;
  assign fill    = occ + {1'b0, rd_pend};
  assign issue   = (state == S_DUMP) && (fill < 2'd2);

  // A read returning with an empty buffer is presented directly on m_data;
  // if it is not taken that cycle it lands in the buffer with the same value,
  // so the stalled output stays stable.
  assign m_valid = (occ != 2'd0) || rd_pend;
  assign m_data  = (occ != 2'd0) ? buf_q[rd_ptr] : (rd_pend ? bank_rdata : '0);
  assign pop     = m_valid && m_ready;
  assign push    = rd_pend && !((occ == 2'd0) && pop);
  assign pop_buf = pop && (occ != 2'd0);

  assign s_ready    = (state == S_LOAD);
  assign bank_we    = beat  ? bank_oh : '0;
  assign bank_re    = issue ? bank_oh : '0;
  assign bank_addr  = (beat || issue) ? paddr : '0;
  assign bank_wdata = beat ? s_data : '0;
  assign bank_set   = set_r;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign err        = (state == S_FIN) && err_r;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_bad)      state_nxt = S_FIN;
          else if (mode[1]) state_nxt = S_DUMP;
          else              state_nxt = S_LOAD;
        end
      end
      S_LOAD:  if (beat && (idx == last_idx))     state_nxt = S_FIN;
      S_DUMP:  if (issue && (idx == last_idx))    state_nxt = S_FLUSH;
      S_FLUSH: if (pop && (out_cnt == last_idx))  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      out_cnt  <= '0;
      last_idx <= '0;
      set_r    <= 1'b0;
      err_r    <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      rd_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= issue;
      if ((state == S_IDLE) && start) begin
        set_r    <= mode[0];
        err_r    <= len_bad;
        last_idx <= IDX_W'(length - (IDX_W+1)'(1));
        idx      <= '0;
        out_cnt  <= '0;
      end else begin
        // Hold at length-1 so the index never wraps within an operation.
        if ((beat || issue) && (idx != last_idx)) idx <= idx + IDX_W'(1);
        if (pop && (out_cnt != last_idx))         out_cnt <= out_cnt + IDX_W'(1);
      end
      if (push) begin
        buf_q[wr_ptr] <= bank_rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_buf) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop_buf};
    end
  end

endmodule

// File: tb/tb_poly_bank_loader.sv
module tb_poly_bank_loader;

  localparam int DATA_W     = 256;
  localparam int NUM_BANKS  = 8;
  localparam int BANK_DEPTH = 128;
  localparam int IDX_W      = 10;
  localparam int ADDR_W     = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [1:0]           mode;
  logic [IDX_W:0]       length;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;
  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  logic                 bank_set;
  logic [ADDR_W-1:0]    bank_addr;
  logic [DATA_W-1:0]    bank_wdata;
  logic [DATA_W-1:0]    bank_rdata;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_W-1:0]    m_data;
  logic                 busy;
  logic                 done;
  logic                 err;

  int total = 0;
  int bad   = 0;

  // Behavioural bank memories and expected contents by logical index.
  logic [DATA_W-1:0] mem     [2][NUM_BANKS][BANK_DEPTH];
  logic [DATA_W-1:0] ref_mem [2][NUM_BANKS*BANK_DEPTH];

  poly_bank_loader #(
    .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BANK_DEPTH(BANK_DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .length(length),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .bank_we(bank_we), .bank_re(bank_re), .bank_set(bank_set),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) mem[bank_set][b][bank_addr] <= bank_wdata;
      if (bank_re[b]) bank_rdata <= mem[bank_set][b][bank_addr];
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned map_idx(input int unsigned i);
    int unsigned r;
    r = i;
`ifdef LOADER_BITREV_EN
    r = 0;
    for (int k = 0; k < IDX_W; k++) if (i[k]) r = r | (1 << (IDX_W - 1 - k));
`endif
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"},  s_ready, 0);
    check({tag, "_we"},       bank_we, 0);
    check({tag, "_re"},       bank_re, 0);
    check({tag, "_set"},      bank_set, 0);
    check({tag, "_addr"},     bank_addr, 0);
    check({tag, "_wdata"},    bank_wdata, 0);
    check({tag, "_m_valid"},  m_valid, 0);
    check({tag, "_m_data"},   m_data, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
  endtask

  // vmode: 0 s_valid high, 1 toggling, 2 random. abort_at < 0: no abort.
  task automatic do_load(input bit set, input int len, input int vmode, input bit idx_data,
                         input int abort_at, input bit fin_start);
    int beats, cyc;
    int unsigned m;
    logic [DATA_W-1:0] d;
    start  = 1'b1;
    mode   = {1'b0, set};
    length = (IDX_W+1)'(len);
    tick();
    start = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < len && cyc < 4 * len + 20) begin
      s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      d       = idx_data ? DATA_W'(beats) : rand_word();
      s_data  = d;
      // A start while busy must be ignored.
      if (vmode == 1 && cyc == 5) begin
        start = 1'b1; mode = 2'b11; length = 11'd3;
      end else start = 1'b0;
      @(negedge clk);
      if (beats == abort_at && s_valid) begin
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        s_valid = 1'b0;
        start   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      check("load_s_ready", s_ready, 1);
      check("load_re", bank_re, 0);
      if (s_valid) begin
        m = map_idx(beats);
        check("load_we", bank_we, NUM_BANKS'(1) << (m % NUM_BANKS));
        check("load_addr", bank_addr, m / NUM_BANKS);
        check("load_wdata", bank_wdata, d);
        check("load_set", bank_set, set);
`ifdef LOADER_BITREV_EN
        if (beats == 1) begin
          check("rev_idx1_we", bank_we, 8'b0000_0001);
          check("rev_idx1_addr", bank_addr, 64);
        end
`else
        if (beats == 9) begin
          check("beat9_we", bank_we, 8'b0000_0010);
          check("beat9_addr", bank_addr, 1);
        end
`endif
        ref_mem[set][beats] = d;
        beats++;
      end else begin
        check("load_idle_we", bank_we, 0);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (beats < len) check("load_timeout", beats, len);
    if (vmode == 0) check("load_cycles", cyc, len);
    s_valid = 1'b0;
    if (fin_start) begin
      start = 1'b1; mode = 2'b00; length = 11'd4;
    end
    @(negedge clk);
    check("load_done", done, 1);
    check("load_err", err, 0);
    check("load_ready_drop", s_ready, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("load_done_once", done, 0);
    check("load_idle", busy, 0);
    tick();
  endtask

  // rmode: 0 m_ready high, 1 random, 2 low for 10 cycles then high.
  task automatic do_dump(input bit set, input int len, input int rmode);
    int outs, reads, cyc, first_v;
    bit stalled;
    logic [DATA_W-1:0] last_d;
    start   = 1'b1;
    mode    = {1'b1, set};
    length  = (IDX_W+1)'(len);
    m_ready = 1'b0;
    tick();
    start   = 1'b0;
    cyc     = 1;
    outs    = 0;
    reads   = 0;
    first_v = -1;
    stalled = 1'b0;
    last_d  = '0;
    while (outs < len && cyc < 8 * len + 40) begin
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : (cyc > 10);
      @(negedge clk);
      check("dump_we", bank_we, 0);
      check("dump_set", bank_set, set);
      if (bank_re != 0) begin
        reads++;
        check("dump_re_onehot", $onehot(bank_re), 1);
      end
      if (rmode == 2 && cyc == 10) check("stall_reads_le2", reads <= 2, 1);
      if (m_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          check("first_valid_lat", cyc, 2);
        end
        if (stalled) check("dump_hold", m_data, last_d);
        if (m_ready) begin
          check("dump_data", m_data, ref_mem[set][outs]);
          outs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          last_d  = m_data;
        end
      end else begin
        check("dump_valid_dropped", stalled, 0);
      end
      tick();
      cyc++;
    end
    if (outs < len) check("dump_timeout", outs, len);
    check("dump_reads", reads, len);
    if (rmode == 0) check("dump_cycles", cyc, len + 2);
    m_ready = 1'b0;
    @(negedge clk);
    check("dump_done", done, 1);
    check("dump_err", err, 0);
    check("dump_valid_end", m_valid, 0);
    tick();
    @(negedge clk);
    check("dump_done_once", done, 0);
    check("dump_idle", busy, 0);
    tick();
  endtask

  task automatic do_err(input int len);
    start  = 1'b1;
    mode   = 2'b00;
    length = (IDX_W+1)'(len);
    @(negedge clk);
    check("err_start_we", bank_we, 0);
    check("err_start_re", bank_re, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_done", done, 1);
    check("err_err", err, 1);
    check("err_we", bank_we, 0);
    check("err_re", bank_re, 0);
    tick();
    @(negedge clk);
    check("err_done_once", done, 0);
    check("err_err_once", err, 0);
    check("err_idle", busy, 0);
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    mode    = 2'b00;
    length  = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    #3 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    do_load(1'b0, 1024, 0, 1'b1, -1, 1'b0);
    do_load(1'b1, 16, 1, 1'b0, -1, 1'b1);
    do_dump(1'b0, 1024, 1);
    do_dump(1'b0, 20, 2);
    do_err(0);
    do_err(1025);
    do_dump(1'b1, 16, 0);
    do_load(1'b1, 1024, 0, 1'b0, 500, 1'b0);
    do_load(1'b1, 4, 0, 1'b0, -1, 1'b0);
    do_dump(1'b1, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_bank_loader.md
Name: poly_bank_loader

Overview:
- Synthesizable replacement for backdoor preloading of the NTT coefficient banks.
- Streams coefficients in over valid/ready and scatters them across NUM_BANKS banks of set A or set B, using interleaved mapping: bank = idx mod NUM_BANKS, addr = idx / NUM_BANKS.
- Also dumps a bank set back out as an ordered stream, with full backpressure, for result readout.
- Sits between the host/DMA stream and the bank_* memories of top_poly_mul.

Parameters:
- DATA_W, 256: coefficient width.
- NUM_BANKS, 8: banks per set; must be a power of 2.
- BANK_DEPTH, 128: words per bank; must be a power of 2.
- IDX_W, 10: coefficient index width; equals log2(NUM_BANKS*BANK_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 load A, 01 load B, 10 dump A, 11 dump B; sampled with start.
- length  in  IDX_W+1  coefficient count; valid range 1..NUM_BANKS*BANK_DEPTH; sampled with start.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- s_data  in  DATA_W  input coefficient.
- bank_we  out  NUM_BANKS  one-hot write enable.
- bank_re  out  NUM_BANKS  one-hot read enable.
- bank_set  out  1  0 = set A, 1 = set B.
- bank_addr  out  log2(BANK_DEPTH)  shared address.
- bank_wdata  out  DATA_W  write data.
- bank_rdata  in  DATA_W  data from the bank selected by bank_re; valid 1 cycle after bank_re.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  DATA_W  output coefficient.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for an illegal length.

Behaviour:
- Reset: state IDLE; counters 0. All outputs 0, including s_ready, bank_we, bank_re, bank_set, bank_addr, bank_wdata, m_valid, m_data, busy, done and err.
- Reset mid-operation aborts immediately. Any partially written bank contents are left as-is.
- States: IDLE, LOAD, DUMP, FLUSH, FIN.
- IDLE:
  - start with length 0 or length > NUM_BANKS*BANK_DEPTH -> FIN with err=1. No bank access.
  - Otherwise mode[1]=0 -> LOAD; mode[1]=1 -> DUMP.
  - bank_set = mode[0] is latched for the whole operation.
  - start outside IDLE is ignored.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready beat writes in the same cycle: bank_we one-hot at idx mod NUM_BANKS, bank_addr = idx / NUM_BANKS, bank_wdata = s_data. Then idx increments.
  - bank_we is 0 on cycles with no beat.
  - After beat length-1: s_ready drops next cycle, go to FIN.
- DUMP:
  - Issues reads in index order into a 2-entry output buffer.
  - A read is issued only when buffer occupancy plus in-flight reads is less than 2, so no data is lost under m_ready=0.
  - m_valid is asserted while the buffer is non-empty. A beat pops on m_valid&&m_ready. m_data/m_valid hold stable while stalled.
  - Once all reads are issued -> FLUSH.
- FLUSH: drain the buffer; after the last output beat -> FIN.
- FIN: done=1 (err as latched) for one cycle -> IDLE.
- Latency:
  - Load: done 1 cycle after the last accepted beat.
  - Dump: first m_valid 2 cycles after start. Sustained throughput is 1 beat/cycle with m_ready held high.
- Index wrap: idx never exceeds length-1; no wrap within an operation.
- Simultaneous events: start coinciding with FIN is ignored; start must be reissued in IDLE.

Optional Feature:
- LOADER_BITREV_EN
  - Defined: the IDX_W-bit index is bit-reversed before the bank/addr mapping, for both load and dump. This gives natural-order input to bit-reversed bank placement for the NTT.
  - Undefined: natural mapping only; no reversal logic is present.

Test Plan:
- Load A, length=1024, data=index, s_valid always high -> 1024 writes in 1024 cycles. Beat 9 hits bank_we=8'b0000_0010, addr=1. done 1 cycle after the last beat. bank_set=0 throughout.
- Load B, length=16, s_valid toggling every other cycle -> exactly 16 writes, bank_set=1, no bank_we on idle cycles, single done pulse.
- Dump A after the first test, m_ready random (50%) -> m_data sequence 0..1023 in order, with no drop and no duplicate.
- Dump with m_ready held low for 10 cycles -> m_valid held with m_data=0 stable, at most 2 reads issued, then resumes in order.
- start with length=0, then with length=1025 -> done and err both pulse once, 1 cycle after start. No bank_we or bank_re asserted.
- Assert rst low mid-load at beat 500 -> all outputs 0 asynchronously. A new load of length=4 then completes normally. With LOADER_BITREV_EN defined, index 1 lands in bank 0, addr 64.
